led_pattern_sequencer: RTL

//  Controller that sequences the board's user LEDs from the internal-oscillator clock domain.

---
 rtl/led_pattern_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/led_pattern_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : led_pattern_sequencer
// Brief    : Steps OFF / BINARY / CHASE / BREATHE LED patterns on a shared
//            prescaler tick, with PWM dimming for BREATHE. Optional macro
//            LED_GAMMA_EN selects a squared BREATHE duty curve.
// Revision : 1.0 - initial release
// ============================================================================
module led_pattern_sequencer #(
    parameter int TICK_DIV = 20800,
    parameter int N_LED    = 3,
    parameter int PWM_W    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mode_valid,
    input  logic [1:0]       mode_data,
    output logic             mode_ready,
    output logic [N_LED-1:0] led,
    output logic             step_tick,
    output logic             busy
);

    localparam int                   c_PRESC_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [c_PRESC_W-1:0] c_TICK_LAST = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [PWM_W-1:0]     c_LEVEL_MAX = {PWM_W{1'b1}};

    localparam logic [1:0] c_MODE_OFF     = 2'd0;
    localparam logic [1:0] c_MODE_BINARY  = 2'd1;
    localparam logic [1:0] c_MODE_CHASE   = 2'd2;
    localparam logic [1:0] c_MODE_BREATHE = 2'd3;

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_BLANK = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [1:0]           r_mode;
    logic [1:0]           w_mode_nxt;
    logic [N_LED-1:0]     r_pattern;
    logic [N_LED-1:0]     w_pattern_nxt;
    logic [PWM_W-1:0]     r_level;
    logic [PWM_W-1:0]     w_level_nxt;
    logic                 r_dir_down;
    logic                 w_dir_down_nxt;
    logic [c_PRESC_W-1:0] r_presc;
    logic [PWM_W-1:0]     r_pwm_cnt;
    logic [N_LED-1:0]     r_led;
    logic [N_LED-1:0]     w_led_nxt;
    logic [PWM_W-1:0]     w_duty;
    logic                 w_pwm_on;
    logic                 w_step;
    logic                 w_accept;

    assign w_step     = enable & (r_presc == c_TICK_LAST);
    assign mode_ready = (r_state != S_BLANK);
    assign w_accept   = mode_valid & mode_ready;
    assign busy       = (r_state != S_OFF);
    assign step_tick  = w_step;
    assign led        = r_led;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_presc   <= '0;
            r_pwm_cnt <= '0;
        end else if (enable) begin
            r_presc   <= (r_presc == c_TICK_LAST) ? '0 : r_presc + c_PRESC_W'(1);
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
        end
    end

`ifdef LED_GAMMA_EN
    logic [2*PWM_W-1:0] w_level_sq;
    assign w_level_sq = {{PWM_W{1'b0}}, r_level} * {{PWM_W{1'b0}}, r_level};
    assign w_duty     = w_level_sq[2*PWM_W-1:PWM_W];
`else
    assign w_duty = r_level;
`endif

    assign w_pwm_on = (r_pwm_cnt < w_duty);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_OFF;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A new request always wins over a coincident step, so it is decoded first.
    always_comb begin
        w_state_nxt    = r_state;
        w_mode_nxt     = r_mode;
        w_pattern_nxt  = r_pattern;
        w_level_nxt    = r_level;
        w_dir_down_nxt = r_dir_down;
        if (w_accept) begin
            w_state_nxt    = S_BLANK;
            w_mode_nxt     = mode_data;
            w_pattern_nxt  = (mode_data == c_MODE_CHASE) ? N_LED'(1) : '0;
            w_level_nxt    = '0;
            w_dir_down_nxt = 1'b0;
        end else begin
            case (r_state)
                S_OFF: ;
                S_BLANK: begin
                    if (w_step) begin
                        w_state_nxt = (r_mode != c_MODE_OFF) ? S_RUN : S_OFF;
                    end
                end
                S_RUN: begin
                    if (w_step) begin
                        case (r_mode)
                            c_MODE_BINARY: w_pattern_nxt = r_pattern + N_LED'(1);
                            c_MODE_CHASE:  w_pattern_nxt = {r_pattern[N_LED-2:0], r_pattern[N_LED-1]};
                            c_MODE_BREATHE: begin
                                if (!r_dir_down) begin
                                    if (r_level == c_LEVEL_MAX) begin
                                        w_dir_down_nxt = 1'b1;
                                        w_level_nxt    = c_LEVEL_MAX - PWM_W'(1);
                                    end else begin
                                        w_level_nxt = r_level + PWM_W'(1);
                                    end
                                end else begin
                                    if (r_level == '0) begin
                                        w_dir_down_nxt = 1'b0;
                                        w_level_nxt    = PWM_W'(1);
                                    end else begin
                                        w_level_nxt = r_level - PWM_W'(1);
                                    end
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                default: w_state_nxt = S_OFF;
            endcase
        end
    end

    always_comb begin
        w_led_nxt = '0;
        if (r_state == S_RUN) begin
            case (r_mode)
                c_MODE_BINARY,
                c_MODE_CHASE:   w_led_nxt = r_pattern;
                c_MODE_BREATHE: w_led_nxt = {N_LED{w_pwm_on}};
                default:        w_led_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= c_MODE_OFF;
            r_pattern  <= '0;
            r_level    <= '0;
            r_dir_down <= 1'b0;
            r_led      <= '0;
        end else begin
            r_mode     <= w_mode_nxt;
            r_pattern  <= w_pattern_nxt;
            r_level    <= w_level_nxt;
            r_dir_down <= w_dir_down_nxt;
            r_led      <= w_led_nxt;
        end
    end

endmodule
`default_nettype wire
